data_mem_arbiter: RTL and testbench

Round-robin arbiter and access sequencer between the processor cores and the shared single-port data RAM. Accepts one memory request at a time from up to CORE_COUNT cores and drives the RAM's write-enable, address and write-data lines. Absorbs the RAM's registered-address read latency, then returns read data with a one-cycle `ready` pulse to the requesting core. It sits directly upstream of the data RAM; every core data access goes through it.

---
 rtl/data_mem_arbiter.sv | 115 +++++++++++
 tb/tb_data_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that sequences one core access at a time onto a single-port data RAM
// whose read data arrives one cycle after the address is presented.
module data_mem_arbiter #(
    parameter int unsigned CORE_COUNT = 4,
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned ID_WIDTH   = $clog2(CORE_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CORE_COUNT-1:0]            req,
    input  logic [CORE_COUNT-1:0]            core_wrEn,
    input  logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr,
    input  logic [CORE_COUNT*WIDTH-1:0]      core_dataIn,
    output logic [CORE_COUNT-1:0]            ready,
    output logic [WIDTH-1:0]                 dataOut,
    output logic                             busy,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             ram_wrEn,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [WIDTH-1:0]                 ram_dataIn,
    input  logic [WIDTH-1:0]                 ram_dataOut
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      dout_q, dout_d;

    logic                  found;
    logic [ID_WIDTH-1:0]   win;
    logic [ID_WIDTH-1:0]   ptr_next;
    int unsigned           idx;

    // Search from rr_ptr upward, wrapping modulo CORE_COUNT; first requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            idx = (32'(rr_ptr_q) + i) % CORE_COUNT;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_WIDTH'(idx);
            end
        end
        ptr_next = (32'(win) == CORE_COUNT - 1) ? '0 : win + ID_WIDTH'(1);
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d  = StIssue;
                    rr_ptr_d = ptr_next;
                    grant_d  = win;
                    wr_d     = core_wrEn[win];
                    addr_d   = core_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d  = core_dataIn[int'(win)*WIDTH +: WIDTH];
                end
            end
            StIssue: state_d = wr_q ? StResp : StWait;
            StWait: begin
                dout_d  = ram_dataOut;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        ram_wrEn   = (state_q == StIssue) && wr_q;
        ready      = (state_q == StResp) ? (CORE_COUNT'(1) << grant_q) : '0;
        grant_id   = grant_q;
        ram_addr   = addr_q;
        ram_dataIn = wdata_q;
        dataOut    = dout_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a behavioural registered-address RAM, directed
// accesses with hand-computed responses, and a monitor that checks every ready pulse.
module tb_data_mem_arbiter;

    localparam int CC = 4;
    localparam int W  = 12;
    localparam int AW = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CC-1:0]    req = '0;
    logic [CC-1:0]    core_wrEn = '0;
    logic [CC*AW-1:0] core_addr = '0;
    logic [CC*W-1:0]  core_dataIn = '0;
    logic [CC-1:0]    ready;
    logic [W-1:0]     dataOut;
    logic             busy;
    logic [1:0]       grant_id;
    logic             ram_wrEn;
    logic [AW-1:0]    ram_addr;
    logic [W-1:0]     ram_dataIn;
    logic [W-1:0]     ram_dataOut;

    data_mem_arbiter #(.CORE_COUNT(CC), .WIDTH(W), .DEPTH(4096)) dut (
        .clk(clk), .rst(rst), .req(req), .core_wrEn(core_wrEn), .core_addr(core_addr),
        .core_dataIn(core_dataIn), .ready(ready), .dataOut(dataOut), .busy(busy),
        .grant_id(grant_id), .ram_wrEn(ram_wrEn), .ram_addr(ram_addr),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    always #5 clk = ~clk;

    // Registered-address RAM model plus cycle and write-pulse bookkeeping.
    logic [W-1:0]  mem [4096];
    logic [AW-1:0] ram_addr_q = '0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            last_wr_cyc = -1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_addr_q <= ram_addr;
        if (ram_wrEn) begin
            mem[ram_addr] <= ram_dataIn;
            wr_cnt <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
    end
    assign ram_dataOut = mem[ram_addr_q];

    typedef struct {
        int       core;
        bit       rd;
        logic [W-1:0] data;
        int       cyc;
    } exp_t;

    exp_t     exp_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    logic [W-1:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ready != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(ready), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("ready_onehot", 32'(ready), 32'(1) << e.core);
                    chk("grant_id", 32'(grant_id), 32'(e.core));
                    chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_in_resp", 32'(busy), 32'(1));
                    chk("wren_in_resp", 32'(ram_wrEn), 32'(0));
                    if (e.rd) begin
                        chk("read_data", 32'(dataOut), 32'(e.data));
                        last_rd = e.data;
                    end else begin
                        chk("dataout_held_after_write", 32'(dataOut), 32'(last_rd));
                    end
                end
            end
        end
    endtask

    task automatic set_core(input int core, input bit wr, input int addr, input int data);
        core_wrEn[core] = wr;
        core_addr[core*AW +: AW] = AW'(addr);
        core_dataIn[core*W +: W] = W'(data);
    endtask

    task automatic expect_resp(input int core, input bit rd, input int data, input int at);
        exp_t e;
        e.core = core;
        e.rd   = rd;
        e.data = W'(data);
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Cores drop req on their own ready pulse; bounded wait for n completions.
    task automatic run_until(input int n);
        int got = 0;
        for (int k = 0; k < 100 && got < n; k++) begin
            @(negedge clk);
            if (ready != '0) begin
                req = req & ~ready;
                got++;
            end
        end
        if (got < n) chk("ready_timeout", 32'(got), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int core, input bit wr, input int addr, input int data);
        set_core(core, wr, addr, wr ? data : 0);
        req[core] = 1'b1;
        expect_resp(core, !wr, data, cyc + (wr ? 2 : 3));
        run_until(1);
    endtask

    int n0;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wren", 32'(ram_wrEn), 32'(0));
        chk("rst_dataout", 32'(dataOut), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        fork
            monitor();
        join_none

        // Write then read back from core 0; RAM write strobe only in the ISSUE cycle.
        n0 = cyc;
        access(0, 1'b1, 5, 12'hABC);
        chk("write_issue_cycle", 32'(last_wr_cyc), 32'(n0 + 1));
        chk("write_count_single", 32'(wr_cnt), 32'(1));
        chk("ram_dataIn_held", 32'(ram_dataIn), 32'(12'hABC));
        access(0, 1'b0, 5, 12'hABC);

        access(1, 1'b1, 7, 12'h777);
        access(1, 1'b1, 9, 12'h999);
        access(1, 1'b1, 12'h011, 12'h111);
        access(2, 1'b1, 12'h022, 12'h222);
        access(3, 1'b1, 12'h033, 12'h333);
        chk("ram_addr_held", 32'(ram_addr), 32'h033);

        // All four cores read together: served 0,1,2,3 at 4-cycle spacing.
        set_core(0, 1'b0, 5, 0);
        set_core(1, 1'b0, 12'h011, 0);
        set_core(2, 1'b0, 12'h022, 0);
        set_core(3, 1'b0, 12'h033, 0);
        req = 4'b1111;
        expect_resp(0, 1'b1, 12'hABC, cyc + 3);
        expect_resp(1, 1'b1, 12'h111, cyc + 7);
        expect_resp(2, 1'b1, 12'h222, cyc + 11);
        expect_resp(3, 1'b1, 12'h333, cyc + 15);
        run_until(4);

        // Pointer wrapped to 0 after serving core 3.
        req = 4'b1001;
        expect_resp(0, 1'b1, 12'hABC, cyc + 3);
        expect_resp(3, 1'b1, 12'h333, cyc + 7);
        run_until(2);

        // Address change during WAIT is ignored.
        set_core(1, 1'b0, 7, 0);
        req[1] = 1'b1;
        expect_resp(1, 1'b1, 12'h777, cyc + 3);
        repeat (2) @(posedge clk);
        #1;
        set_core(1, 1'b0, 9, 0);
        @(negedge clk);
        chk("ram_addr_stable_in_wait", 32'(ram_addr), 32'(7));
        run_until(1);

        // Reset during WAIT of a core-2 read: no ready, outputs cleared at once.
        set_core(2, 1'b0, 12'h022, 0);
        req[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_reset", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_ready", 32'(ready), 32'(0));
        chk("mid_rst_grant", 32'(grant_id), 32'(0));
        chk("mid_rst_addr", 32'(ram_addr), 32'(0));
        chk("mid_rst_dataout", 32'(dataOut), 32'(0));
        chk("mid_rst_dataIn", 32'(ram_dataIn), 32'(0));
        chk("mid_rst_wren", 32'(ram_wrEn), 32'(0));
        req = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_core(0, 1'b0, 5, 0);
        set_core(3, 1'b0, 12'h033, 0);
        req = 4'b1001;
        expect_resp(0, 1'b1, 12'hABC, cyc + 3);
        expect_resp(3, 1'b1, 12'h333, cyc + 7);
        run_until(2);

        // Top address, no wrap.
        access(2, 1'b1, 4095, 12'h00F);
        access(0, 1'b0, 4095, 12'h00F);
        chk("top_addr", 32'(ram_addr), 32'hFFF);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        chk("total_writes", 32'(wr_cnt), 32'(7));
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
